// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM states, CPU-visible
// addresses and the RX status word layout.
package uart_receiver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_e;

   localparam logic [31:0] UART_ADDR         = 32'h1000_0000;
   localparam logic [31:0] UART_RX_DATA_ADDR = 32'h1000_0004;
   localparam logic [31:0] UART_RX_STAT_ADDR = 32'h1000_0008;

   // Status word: {27'b0, overrun, frame_err, rx_valid, 2'b0}
   localparam int STAT_RX_VALID_BIT  = 2;
   localparam int STAT_FRAME_ERR_BIT = 3;
   localparam int STAT_OVERRUN_BIT   = 4;

   function automatic logic [31:0] rx_status_word(input logic overrun,
                                                  input logic frame_err,
                                                  input logic rx_valid);
      return {27'b0, overrun, frame_err, rx_valid, 2'b0};
   endfunction

endpackage

// File: rtl/uart_receiver_fifo.sv
// Small byte queue for received characters: show-ahead head, wrap-bit
// pointers, simultaneous push/pop allowed when full.
module rx_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [7:0]                 din_i,
   input  logic                       pop_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [7:0]                 head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

   // A pop on an empty queue is dropped; a pop frees the slot a same-cycle push needs.
   assign do_pop   = pop_i && !empty_o;
   assign do_push  = push_i && (!full_o || do_pop);
   assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver: synchronises the rx pin, deserialises LSB-first
// frames and queues good bytes for the CPU, with sticky error flags.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 234,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            uart_rx,
   input  logic                            rd_en,
   input  logic                            err_clr,
   output logic [7:0]                      rd_data,
   output logic                            rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]     rx_count,
   output logic                            frame_err,
   output logic                            overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sr_q, sr_d;
   logic          sync1_q, rx_s_q;
   logic          wait_high_q, wait_high_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          push, set_fe, set_ov;
   logic          fifo_full, fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         sr_q        <= '0;
         wait_high_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= uart_rx;
         rx_s_q      <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sr_q        <= sr_d;
         wait_high_q <= wait_high_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      sr_d        = sr_q;
      wait_high_d = wait_high_q && !rx_s_q;
      push        = 1'b0;
      set_fe      = 1'b0;
      set_ov      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // After a framing error the line must return high before a new start bit counts.
            if (!rx_s_q && !wait_high_q) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s_q ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == FULL_M1) begin
               sr_d[idx_q] = rx_s_q;
               cnt_d       = '0;
               if (idx_q == 3'd7) state_d = ST_STOP;
               else               idx_d   = idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (rx_s_q) begin
                  if (!fifo_full || rd_en) push   = 1'b1;
                  else                     set_ov = 1'b1;
               end else begin
                  set_fe      = 1'b1;
                  wait_high_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      frame_err_d = set_fe || (frame_err_q && !err_clr);
      overrun_d   = set_ov || (overrun_q && !err_clr);
   end

   rx_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (sr_q),
      .pop_i   (rd_en),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (rx_count),
      .head_o  (rd_data)
   );

   assign rx_valid  = !fifo_empty;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed scenarios plus randomized frames checked
// against a byte-queue model of the receive path.
module tb_uart_receiver;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;
   localparam int CNTW  = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            uart_rx;
   logic            rd_en;
   logic            err_clr;
   logic [7:0]      rd_data;
   logic            rx_valid;
   logic [CNTW-1:0] rx_count;
   logic            frame_err;
   logic            overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic       exp_fe;
   logic       exp_ov;

   logic            lat_before_valid;
   logic            lat_after_valid;
   logic [7:0]      lat_after_data;
   logic [CNTW-1:0] lat_after_count;

   uart_receiver #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .rd_en     (rd_en),
      .err_clr   (err_clr),
      .rd_data   (rd_data),
      .rx_valid  (rx_valid),
      .rx_count  (rx_count),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Model: a frame's stop-bit sample either queues the byte, flags overrun
   // when no room, or flags a framing error; a same-cycle pop goes first.
   function automatic void model_frame(input logic [7:0] b, input bit stop_ok,
                                       input bit pop_same);
      if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
      if (!stop_ok)                exp_fe = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                         exp_ov = 1'b1;
   endfunction

   function automatic logic [7:0] model_head();
      return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
   endfunction

   // mode 1: capture outputs around the push edge; mode 2: pop on the push edge.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int mode);
      logic v;
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      v = 1'b0;
         else if (k == 9) v = stop_ok;
         else             v = b[k-1];
         uart_rx = v;
         if (k < 9) begin
            repeat (CPB) @(negedge clk);
         end else begin
            repeat (CPB - 2) @(negedge clk);
            lat_before_valid = rx_valid;
            if (mode == 2) rd_en = 1'b1;
            @(negedge clk);
            rd_en           = 1'b0;
            lat_after_valid = rx_valid;
            lat_after_data  = rd_data;
            lat_after_count = rx_count;
            @(negedge clk);
         end
      end
      uart_rx = 1'b1;
      if (!stop_ok) repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_fe  = 1'b0;
      exp_ov  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; uart_rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      exp_q.delete(); exp_fe = 1'b0; exp_ov = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rx_valid); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h want 00", rd_data); end
      checks++; if (rx_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", rx_count); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %0b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %0b want 0", overrun); end
   endtask

   task automatic test_single();
      send_frame(8'hA5, 1'b1, 1);
      model_frame(8'hA5, 1'b1, 1'b0);
      checks++; if (lat_before_valid !== 1'b0) begin errors++; $display("FAIL single_early: valid got %0b want 0", lat_before_valid); end
      checks++; if (lat_after_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", lat_after_valid); end
      checks++; if (lat_after_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h want a5", lat_after_data); end
      checks++; if (lat_after_count !== CNTW'(1)) begin errors++; $display("FAIL single_count: got %0d want 1", lat_after_count); end
      pop_one();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %0b want 0", rx_valid); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL single_pop_data: got %0h want 00", rd_data); end
   endtask

   task automatic test_glitch();
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %0b want 0", rx_valid); end
      checks++; if (rx_count !== '0) begin errors++; $display("FAIL glitch_count: got %0d want 0", rx_count); end
      checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %0b want 00", {frame_err, overrun}); end
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0, 0);
      model_frame(8'h3C, 1'b0, 1'b0);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_set: got %0b want 1", frame_err); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL fe_nothing_queued: got %0b want 0", rx_valid); end
      pulse_err_clr();
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_clear: got %0b want 0", frame_err); end
      send_frame(8'h3C, 1'b1, 0);
      model_frame(8'h3C, 1'b1, 1'b0);
      checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL fe_next_data: got %0h want 3c", rd_data); end
      checks++; if (rx_count !== CNTW'(1)) begin errors++; $display("FAIL fe_next_count: got %0d want 1", rx_count); end
      pop_one();
   endtask

   task automatic test_overrun();
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 0);
         model_frame(8'(i), 1'b1, 1'b0);
      end
      checks++; if (rx_count !== CNTW'(4)) begin errors++; $display("FAIL ovr_count: got %0d want 4", rx_count); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
      for (int i = 1; i <= 4; i++) begin
         checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL ovr_read%0d: got %0h want %0h", i, rd_data, 8'(i)); end
         pop_one();
      end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained: got %0b want 0", rx_valid); end
      pulse_err_clr();
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %0b want 0", overrun); end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] fill [4];
      fill[0] = 8'h10; fill[1] = 8'h20; fill[2] = 8'h30; fill[3] = 8'h40;
      for (int i = 0; i < 4; i++) begin
         send_frame(fill[i], 1'b1, 0);
         model_frame(fill[i], 1'b1, 1'b0);
      end
      send_frame(8'h77, 1'b1, 2);
      model_frame(8'h77, 1'b1, 1'b1);
      checks++; if (overrun !== exp_ov) begin errors++; $display("FAIL pp_overrun: got %0b want %0b", overrun, exp_ov); end
      checks++; if (rx_count !== CNTW'(exp_q.size())) begin errors++; $display("FAIL pp_count: got %0d want %0d", rx_count, exp_q.size()); end
      while (exp_q.size() > 0) begin
         checks++; if (rd_data !== model_head()) begin errors++; $display("FAIL pp_read: got %0h want %0h", rd_data, model_head()); end
         pop_one();
      end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL pp_drained: got %0b want 0", rx_valid); end
   endtask

   task automatic test_mid_reset();
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b0, 0);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete(); exp_fe = 1'b0; exp_ov = 1'b0;
      @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %0b want 0", rx_valid); end
      checks++; if (rx_count !== '0) begin errors++; $display("FAIL mrst_count: got %0d want 0", rx_count); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mrst_fe: got %0b want 0", frame_err); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mrst_data: got %0h want 00", rd_data); end
      repeat (2 * CPB) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mrst_no_partial: got %0b want 0", rx_valid); end
      send_frame(8'h5A, 1'b1, 0);
      model_frame(8'h5A, 1'b1, 1'b0);
      checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL mrst_next: got %0h want 5a", rd_data); end
      pop_one();
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         ok;
      int         mode;
      int         nrd;
      for (int it = 0; it < 40; it++) begin
         b    = 8'($urandom_range(0, 255));
         ok   = ($urandom_range(0, 7) != 0);
         mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
         send_frame(b, ok, mode);
         model_frame(b, ok, mode == 2);
         checks++; if (rx_count !== CNTW'(exp_q.size())) begin errors++; $display("FAIL rnd_count it%0d: got %0d want %0d", it, rx_count, exp_q.size()); end
         checks++; if (rd_data !== model_head()) begin errors++; $display("FAIL rnd_head it%0d: got %0h want %0h", it, rd_data, model_head()); end
         checks++; if (rx_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_valid it%0d: got %0b", it, rx_valid); end
         checks++; if ({frame_err, overrun} !== {exp_fe, exp_ov}) begin errors++; $display("FAIL rnd_flags it%0d: got %0b want %0b", it, {frame_err, overrun}, {exp_fe, exp_ov}); end
         nrd = $urandom_range(0, 2);
         for (int r = 0; r < nrd; r++) begin
            checks++; if (rd_data !== model_head()) begin errors++; $display("FAIL rnd_read it%0d: got %0h want %0h", it, rd_data, model_head()); end
            pop_one();
         end
         if ($urandom_range(0, 4) == 0) pulse_err_clr();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_push_pop_full();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
